// File: rtl/e203_dtcm_sram_ctrl_pkg.sv
// e203_dtcm_sram_ctrl_pkg: shared DTCM widths and power-state encoding.
package e203_dtcm_sram_ctrl_pkg;
  localparam int ICB_AW = 16;
  localparam int DTCM_AW = 14;
  localparam int DTCM_DW = 32;
  localparam int DTCM_MW = 4;
  typedef enum logic [1:0] {PWR_ACTIVE = 2'd0, PWR_SLEEP = 2'd1, PWR_WAKE = 2'd2} pwr_state_e;
endpackage

// File: rtl/e203_dtcm_sram_ctrl_ls.sv
// e203_sram_ls_ctrl: idle counter and light-sleep power FSM for the DTCM SRAM.
module e203_sram_ls_ctrl
  import e203_dtcm_sram_ctrl_pkg::*;
#(
  parameter int LS_EN   = 1,
  parameter int LS_IDLE = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_mode_i,
  input  logic cmd_valid_i,
  input  logic rsp_pend_i,
  output logic sleep_o,
  output logic ram_ls_o
);
  pwr_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic idle, go_sleep;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_ACTIVE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    idle     = ~cmd_valid_i & ~rsp_pend_i;
    go_sleep = (cnt_q == 4'(LS_IDLE)) & (LS_EN != 0) & ~test_mode_i;
    cnt_d    = (state_q == PWR_ACTIVE && idle) ? ((cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1) : 4'd0;
    state_d  = (state_q == PWR_ACTIVE) ? (go_sleep ? PWR_SLEEP : PWR_ACTIVE) :
               (state_q == PWR_SLEEP)  ? ((cmd_valid_i | test_mode_i) ? PWR_WAKE : PWR_SLEEP) :
                                         PWR_ACTIVE;
  end
  // ls follows the flopped state but test_mode overrides it immediately
  always_comb begin
    sleep_o  = (state_q == PWR_SLEEP);
    ram_ls_o = sleep_o & ~test_mode_i;
  end
endmodule

// File: rtl/e203_dtcm_sram_ctrl.sv
// e203_dtcm_sram_ctrl: ICB-to-DTCM SRAM bridge with one-deep response stage
// and idle light-sleep control.
module e203_dtcm_sram_ctrl
  import e203_dtcm_sram_ctrl_pkg::*;
#(
  parameter int LS_EN   = 1,
  parameter int LS_IDLE = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               test_mode,
  input  logic               icb_cmd_valid,
  output logic               icb_cmd_ready,
  input  logic               icb_cmd_read,
  input  logic [ICB_AW-1:0]  icb_cmd_addr,
  input  logic [DTCM_DW-1:0] icb_cmd_wdata,
  input  logic [DTCM_MW-1:0] icb_cmd_wmask,
  output logic               icb_rsp_valid,
  input  logic               icb_rsp_ready,
  output logic [DTCM_DW-1:0] icb_rsp_rdata,
  output logic               icb_rsp_err,
  output logic               dtcm_ram_cs,
  output logic               dtcm_ram_we,
  output logic [DTCM_AW-1:0] dtcm_ram_addr,
  output logic [DTCM_MW-1:0] dtcm_ram_wem,
  output logic [DTCM_DW-1:0] dtcm_ram_din,
  input  logic [DTCM_DW-1:0] dtcm_ram_dout,
  output logic               dtcm_ram_sd,
  output logic               dtcm_ram_ds,
  output logic               dtcm_ram_ls
);
  logic pend_q, pend_d, first_q, first_d, err_q, err_d, rd_q, rd_d;
  logic [DTCM_DW-1:0] hold_q, hold_d;
  logic sleep, cmd_hs, aligned;
  e203_sram_ls_ctrl #(.LS_EN(LS_EN), .LS_IDLE(LS_IDLE)) u_ls (
    .clk         (clk),
    .rst_n       (rst_n),
    .test_mode_i (test_mode),
    .cmd_valid_i (icb_cmd_valid),
    .rsp_pend_i  (pend_q),
    .sleep_o     (sleep),
    .ram_ls_o    (dtcm_ram_ls)
  );
  always_comb begin
    icb_cmd_ready = ~sleep & (~pend_q | icb_rsp_ready);
    cmd_hs        = icb_cmd_valid & icb_cmd_ready;
    aligned       = (icb_cmd_addr[1:0] == 2'b00);
    dtcm_ram_cs   = cmd_hs & aligned;
    dtcm_ram_we   = dtcm_ram_cs & ~icb_cmd_read;
    dtcm_ram_addr = dtcm_ram_cs ? icb_cmd_addr[ICB_AW-1:2] : '0;
    dtcm_ram_wem  = dtcm_ram_we ? icb_cmd_wmask : '0;
    dtcm_ram_din  = dtcm_ram_cs ? icb_cmd_wdata : '0;
    dtcm_ram_sd   = 1'b0;
    dtcm_ram_ds   = 1'b0;
  end
  // SRAM dout is only valid in the first response cycle, so it is held afterwards
  always_comb begin
    pend_d        = cmd_hs | (pend_q & ~icb_rsp_ready);
    first_d       = cmd_hs;
    err_d         = cmd_hs ? ~aligned : err_q;
    rd_d          = cmd_hs ? icb_cmd_read : rd_q;
    hold_d        = first_q ? dtcm_ram_dout : hold_q;
    icb_rsp_valid = pend_q;
    icb_rsp_err   = pend_q & err_q;
    icb_rsp_rdata = (pend_q & rd_q & ~err_q) ? (first_q ? dtcm_ram_dout : hold_q) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      first_q <= first_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
    end
  end
endmodule
